// File: rtl/tcam_pkg.sv
// -----------------------------------------------------------------------------
// tcam_pkg
// Shared defaults and types for the ternary CAM.
//   TCAM_WIDTH : default key/entry width in bits
//   TCAM_DEPTH : default number of entries
//   TCAM_AW    : default address width, $clog2(TCAM_DEPTH)
//   entry_t    : one stored entry {value, care, valid}. Don't-care bits of
//                value are held at 0.
// -----------------------------------------------------------------------------
package tcam_pkg;

  localparam int TCAM_WIDTH = 16;
  localparam int TCAM_DEPTH = 16;
  localparam int TCAM_AW    = 4;

  typedef struct packed {
    logic [TCAM_WIDTH-1:0] value;
    logic [TCAM_WIDTH-1:0] care;
    logic                  valid;
  } entry_t;

endpackage : tcam_pkg

// File: rtl/tcam_prio_enc.sv
// -----------------------------------------------------------------------------
// tcam_prio_enc
// Combinational priority encoder: reports whether any match bit is set and
// the index of the lowest set bit.
// Ports:
//   i_match [DEPTH-1:0] : per-entry match vector
//   o_hit               : 1 when any bit of i_match is set
//   o_idx   [AW-1:0]    : index of the lowest set bit (0 when o_hit = 0)
// -----------------------------------------------------------------------------
module tcam_prio_enc #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic [DEPTH-1:0] i_match,
  output logic             o_hit,
  output logic [AW-1:0]    o_idx
);

  logic [AW-1:0] w_idx;

  // Scan from the top down so the last assignment is the lowest set index.
  always_comb begin
    w_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_idx = i_match[i] ? AW'(i) : w_idx;
    end
  end

  assign o_hit = |i_match;
  assign o_idx = w_idx;

endmodule : tcam_prio_enc

// File: rtl/tcam.sv
// -----------------------------------------------------------------------------
// tcam
// Ternary content-addressable memory with DEPTH entries of WIDTH bits.
// Entries are written by address as {value, care mask}; a search compares a
// ternary key against every valid entry in parallel and registers the lowest
// matching address and its stored value one cycle later.
// Optional feature (macro TCAM_CLEAR_EN): adds input i_clear, which
// invalidates every entry and takes priority over a same-cycle write.
// Ports:
//   i_clk    : clock, all state on posedge
//   i_rst    : asynchronous active-high reset
//   i_we     : write strobe, entry i_waddr <= {i_data & i_mask, i_mask}
//   i_waddr  : write address (addresses >= DEPTH are ignored)
//   i_data   : write value or search key
//   i_search : search strobe
//   o_saddr  : lowest matching entry address (0 on miss)
//   o_sdata  : stored value of the matching entry (0 on miss)
//   o_found  : 1 when the last search hit a valid entry
//   i_mask   : care mask for writes and searches, 1 = care
//   i_clear  : (TCAM_CLEAR_EN only) invalidate all entries
// -----------------------------------------------------------------------------
module tcam
  import tcam_pkg::*;
#(
  parameter int WIDTH = TCAM_WIDTH,
  parameter int DEPTH = TCAM_DEPTH,
  parameter int AW    = TCAM_AW
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_search,
  output logic [AW-1:0]    o_saddr,
  output logic [WIDTH-1:0] o_sdata,
  output logic             o_found,
`ifdef TCAM_CLEAR_EN
  input  logic [WIDTH-1:0] i_mask,
  input  logic             i_clear
`else
  input  logic [WIDTH-1:0] i_mask
`endif
);

  // Storage, kept under these exact names for hierarchical inspection.
  logic [WIDTH-1:0] mem   [DEPTH];
  logic [WIDTH-1:0] care  [DEPTH];
  logic [DEPTH-1:0] valid;

  logic [DEPTH-1:0] w_match;
  logic             w_hit;
  logic [AW-1:0]    w_idx;
  logic             w_wr_ok;

  logic [AW-1:0]    r_saddr;
  logic [WIDTH-1:0] r_sdata;
  logic             r_found;

  // A bit participates only where both the entry and the key care about it.
  function automatic logic ternary_match(
    input logic [WIDTH-1:0] f_value,
    input logic [WIDTH-1:0] f_care,
    input logic [WIDTH-1:0] f_key,
    input logic [WIDTH-1:0] f_kmask
  );
    return ((f_value ^ f_key) & f_care & f_kmask) == '0;
  endfunction

  assign w_wr_ok = i_we && ({1'b0, i_waddr} < (AW+1)'(DEPTH));

  // Entry storage: reset, optional bulk invalidate, then addressed write.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i]  <= '0;
        care[i] <= '0;
      end
      valid <= '0;
    end
`ifdef TCAM_CLEAR_EN
    else if (i_clear) begin
      valid <= '0;
    end
`endif
    else if (w_wr_ok) begin
      mem[i_waddr]   <= i_data & i_mask;
      care[i_waddr]  <= i_mask;
      valid[i_waddr] <= 1'b1;
    end
  end

  // Parallel compare of the key against every stored entry.
  always_comb begin
    w_match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_match[i] = valid[i] && ternary_match(mem[i], care[i], i_data, i_mask);
    end
  end

  tcam_prio_enc #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_prio_enc (
    .i_match (w_match),
    .o_hit   (w_hit),
    .o_idx   (w_idx)
  );

  // Search result registers; they hold whenever no search is issued. The
  // compare uses pre-edge storage, so a same-cycle write is not visible yet.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_found <= 1'b0;
      r_saddr <= '0;
      r_sdata <= '0;
    end else if (i_search) begin
      r_found <= w_hit;
      r_saddr <= w_hit ? w_idx : '0;
      r_sdata <= w_hit ? mem[w_idx] : '0;
    end else begin
      r_found <= r_found;
      r_saddr <= r_saddr;
      r_sdata <= r_sdata;
    end
  end

  assign o_found = r_found;
  assign o_saddr = r_saddr;
  assign o_sdata = r_sdata;

endmodule : tcam

// File: tb/tb_tcam.sv
// -----------------------------------------------------------------------------
// tb_tcam
// Self-checking bench for tcam: directed vector table, write/search overlap
// and mid-sequence reset sequences, then randomized traffic compared against
// a bit-by-bit behavioural model of the ternary lookup.
// -----------------------------------------------------------------------------
module tb_tcam;
  import tcam_pkg::*;

  localparam int W = TCAM_WIDTH;
  localparam int D = TCAM_DEPTH;
  localparam int A = TCAM_AW;

  logic         clk = 1'b0;
  logic         rst;
  logic         we;
  logic [A-1:0] waddr;
  logic [W-1:0] data;
  logic [W-1:0] mask;
  logic         search;
  logic [A-1:0] saddr;
  logic [W-1:0] sdata;
  logic         found;
  logic         clear;

  tcam dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_we     (we),
    .i_waddr  (waddr),
    .i_data   (data),
    .i_search (search),
    .o_saddr  (saddr),
    .o_sdata  (sdata),
    .o_found  (found),
`ifdef TCAM_CLEAR_EN
    .i_mask   (mask),
    .i_clear  (clear)
`else
    .i_mask   (mask)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  entry_t       ref_e [D];
  logic         exp_found;
  logic [A-1:0] exp_saddr;
  logic [W-1:0] exp_sdata;

  typedef struct {
    logic         we;
    logic [A-1:0] waddr;
    logic [W-1:0] data;
    logic [W-1:0] mask;
    logic         search;
    logic         e_found;
    logic [A-1:0] e_saddr;
    logic [W-1:0] e_sdata;
  } vec_t;

  vec_t vt [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input logic f, input logic [A-1:0] a,
                           input logic [W-1:0] v);
    check({tag, ".found"}, 32'(found), 32'(f));
    check({tag, ".saddr"}, 32'(saddr), 32'(a));
    check({tag, ".sdata"}, 32'(sdata), 32'(v));
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) ref_e[i] = '0;
    exp_found = 1'b0;
    exp_saddr = '0;
    exp_sdata = '0;
  endtask

  // Lowest entry where every bit either agrees or is ignored by entry or key.
  task automatic model_search(input logic [W-1:0] key, input logic [W-1:0] kmask);
    exp_found = 1'b0;
    exp_saddr = '0;
    exp_sdata = '0;
    for (int i = 0; i < D; i++) begin
      bit ok;
      ok = ref_e[i].valid;
      for (int b = 0; b < W; b++) begin
        if (ref_e[i].care[b] && kmask[b] && (ref_e[i].value[b] != key[b])) ok = 0;
      end
      if (ok && !exp_found) begin
        exp_found = 1'b1;
        exp_saddr = A'(i);
        exp_sdata = ref_e[i].value;
      end
    end
  endtask

  // Applies one clock of stimulus to DUT and model; returns #1 after the edge.
  task automatic do_cycle(input logic i_we, input logic [A-1:0] i_wa, input logic [W-1:0] i_d,
                          input logic [W-1:0] i_m, input logic i_s, input logic i_c);
    we = i_we; waddr = i_wa; data = i_d; mask = i_m; search = i_s; clear = i_c;
    if (i_s) model_search(i_d, i_m);
`ifdef TCAM_CLEAR_EN
    if (i_c) begin
      for (int i = 0; i < D; i++) ref_e[i].valid = 1'b0;
    end else
`endif
    if (i_we && (int'(i_wa) < D)) begin
      ref_e[i_wa].value = i_d & i_m;
      ref_e[i_wa].care  = i_m;
      ref_e[i_wa].valid = 1'b1;
    end
    @(posedge clk);
    #1;
    we = 1'b0; search = 1'b0; clear = 1'b0;
  endtask

  task automatic dump_check(input string tag);
    for (int i = 0; i < D; i++) begin
      check($sformatf("%s.mem[%0d]", tag, i), 32'(dut.mem[i]), 32'(ref_e[i].value));
    end
  endtask

  initial begin
    logic [W-1:0] pool [8];
    logic [W-1:0] m, d;
    logic         c;

    rst = 1'b1; we = 1'b0; waddr = '0; data = '0; mask = '0; search = 1'b0; clear = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 1'b0, '0, '0);
    rst = 1'b0;

    // Directed table: reset search, four ternary writes (x bits driven 1 in
    // data so masking on store is visible), then searches and a hold cycle.
    vt[0] = '{1'b0, 4'd0,  16'h1234, 16'hFFFF, 1'b1, 1'b0, 4'd0,  16'h0000};
    vt[1] = '{1'b1, 4'd0,  16'h05D5, 16'hFF7F, 1'b0, 1'b0, 4'd0,  16'h0000};
    vt[2] = '{1'b1, 4'd4,  16'h0555, 16'hFFEF, 1'b0, 1'b0, 4'd0,  16'h0000};
    vt[3] = '{1'b1, 4'd10, 16'hB55D, 16'h7FEB, 1'b0, 1'b0, 4'd0,  16'h0000};
    vt[4] = '{1'b1, 4'd13, 16'hB55F, 16'hFFF1, 1'b0, 1'b0, 4'd0,  16'h0000};
    vt[5] = '{1'b0, 4'd0,  16'h0551, 16'hFFF3, 1'b1, 1'b1, 4'd0,  16'h0555};
    vt[6] = '{1'b0, 4'd0,  16'h3545, 16'h7FE7, 1'b1, 1'b1, 4'd10, 16'h3549};
    vt[7] = '{1'b0, 4'd0,  16'h357D, 16'hFFFF, 1'b1, 1'b0, 4'd0,  16'h0000};
    vt[8] = '{1'b0, 4'd0,  16'hBEEF, 16'h0000, 1'b1, 1'b1, 4'd0,  16'h0555};
    vt[9] = '{1'b0, 4'd0,  16'h357D, 16'hFFFF, 1'b0, 1'b1, 4'd0,  16'h0555};

    for (int i = 0; i < 10; i++) begin
      do_cycle(vt[i].we, vt[i].waddr, vt[i].data, vt[i].mask, vt[i].search, 1'b0);
      check_out($sformatf("vec%0d", i), vt[i].e_found, vt[i].e_saddr, vt[i].e_sdata);
    end
    check("dump.mem0",  32'(dut.mem[0]),  32'h0555);
    check("dump.mem4",  32'(dut.mem[4]),  32'h0545);
    check("dump.mem10", 32'(dut.mem[10]), 32'h3549);
    check("dump.mem13", 32'(dut.mem[13]), 32'hB551);
    dump_check("dump");

    // Same-cycle write and search: search sees the old contents.
    do_cycle(1'b1, 4'd0, 16'h1234, 16'hFFFF, 1'b1, 1'b0);
    check_out("wrsrch.old", 1'b0, 4'd0, 16'h0000);
    do_cycle(1'b0, 4'd0, 16'h1234, 16'hFFFF, 1'b1, 1'b0);
    check_out("wrsrch.new", 1'b1, 4'd0, 16'h1234);

    // Asynchronous reset between edges clears outputs and storage at once.
    #2;
    rst = 1'b1;
    #1;
    check_out("midrst", 1'b0, '0, '0);
    check("midrst.mem0", 32'(dut.mem[0]), 32'h0000);
    check("midrst.valid", 32'(dut.valid), 32'h0000);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    do_cycle(1'b0, 4'd0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    check_out("postrst", 1'b0, '0, '0);

    // Randomized traffic against the model.
    for (int i = 0; i < 8; i++) pool[i] = W'($urandom);
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0:       m = '0;
        1:       m = '1;
        2:       m = W'($urandom);
        default: m = W'($urandom) & W'($urandom);
      endcase
      d = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 7)] : W'($urandom);
`ifdef TCAM_CLEAR_EN
      c = ($urandom_range(0, 49) == 0);
`else
      c = 1'b0;
`endif
      do_cycle(($urandom_range(0, 2) == 0), A'($urandom), d, m,
               ($urandom_range(0, 1) == 1), c);
      check_out($sformatf("rand%0d", n), exp_found, exp_saddr, exp_sdata);
    end
    dump_check("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_tcam
